// File: rtl/gray_counter_pkg.sv
// Shared definitions for the Gray counter and its neighbours in the Gray-code datapath.
package gray_counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_LOAD,
    OP_UP,
    OP_DOWN
  } op_e;

endpackage

// File: rtl/bin_to_gray.sv
// Combinational binary to reflected-Gray converter.
module bin_to_gray
  import gray_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] g
);

  assign g = b ^ (b >> 1);

endmodule

// File: rtl/gray_counter.sv
// Up/down counter with a binary shadow register and a registered reflected-Gray output.
module gray_counter
  import gray_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] g,
  output logic             wrap,
  output logic             step
);

  localparam logic [WIDTH-1:0] MAX_B  = '1;
  localparam logic [WIDTH-1:0] ZERO_B = '0;
  localparam logic [WIDTH-1:0] ONE_B  = {{(WIDTH-1){1'b0}}, 1'b1};

  op_e              op;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] next_b;
  logic [WIDTH-1:0] next_g;
  logic             next_wrap;
  logic             next_step;

  // load outranks a step; direction only matters when stepping
  always_comb begin
    op = OP_HOLD;
    if (load) begin
      op = OP_LOAD;
    end else if (en) begin
      op = up ? OP_UP : OP_DOWN;
    end
  end

  always_comb begin
    next_b    = b;
    next_wrap = 1'b0;
    next_step = 1'b0;
    case (op)
      OP_LOAD: next_b = load_bin;
      OP_UP: begin
        next_b    = b + ONE_B;
        next_step = 1'b1;
        next_wrap = (b == MAX_B);
      end
      OP_DOWN: begin
        next_b    = b - ONE_B;
        next_step = 1'b1;
        next_wrap = (b == ZERO_B);
      end
      default: ;
    endcase
  end

  bin_to_gray #(.WIDTH(WIDTH)) u_b2g (
    .b (next_b),
    .g (next_g)
  );

  // register stage: g is always taken from the converter on next_b, never from b
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b    <= '0;
      g    <= '0;
      wrap <= 1'b0;
      step <= 1'b0;
    end else begin
      b    <= next_b;
      g    <= next_g;
      wrap <= next_wrap;
      step <= next_step;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter: scoreboard of expected g/wrap/step plus literal Gray sequences.
module tb_gray_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_bin = 4'h0;
  logic [3:0] g;
  logic       wrap;
  logic       step;

  typedef struct packed {
    logic [3:0] g;
    logic       wrap;
    logic       step;
  } exp_t;

  exp_t       sb_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] mb = 4'h0;
  logic [3:0] up_seq [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                              4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

  gray_counter #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_bin (load_bin),
    .g        (g),
    .wrap     (wrap),
    .step     (step)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] to_gray(input logic [3:0] v);
    return v ^ (v >> 1);
  endfunction

  // drive one cycle, push the model's expectation, compare after the edge
  task automatic apply(input logic ld, input logic [3:0] lb, input logic e, input logic u,
                       input string tag);
    exp_t       x;
    logic [3:0] nb;
    logic [3:0] prev_g;
    load = ld; load_bin = lb; en = e; up = u;
    x.wrap = 1'b0;
    x.step = 1'b0;
    nb = mb;
    if (ld) begin
      nb = lb;
    end else if (e) begin
      x.step = 1'b1;
      if (u) begin
        x.wrap = (mb == 4'hF);
        nb = mb + 4'h1;
      end else begin
        x.wrap = (mb == 4'h0);
        nb = mb - 4'h1;
      end
    end
    x.g = to_gray(nb);
    mb = nb;
    sb_q.push_back(x);
    prev_g = g;
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    check({tag, " g"}, g, x.g);
    check({tag, " wrap"}, wrap, x.wrap);
    check({tag, " step"}, step, x.step);
    if (x.step) check({tag, " hamming"}, $countones(g ^ prev_g), 1);
  endtask

  // async reset asserted between edges; outputs must clear before the next edge
  task automatic mid_reset(input string tag);
    #2;
    rst = 1'b1;
    load = 1'b0; en = 1'b0; up = 1'b0;
    #1;
    check({tag, " g"}, g, 4'h0);
    check({tag, " wrap"}, wrap, 1'b0);
    check({tag, " step"}, step, 1'b0);
    mb = 4'h0;
    sb_q.delete();
    @(posedge clk);
    #1;
    check({tag, " held g"}, g, 4'h0);
    rst = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check("por g", g, 4'h0);
    check("por wrap", wrap, 1'b0);
    check("por step", step, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      apply(1'b0, 4'h0, 1'b1, 1'b1, "up16");
      check("up16 seq", g, up_seq[i]);
      check("up16 wrap lit", wrap, (i == 15));
    end

    mid_reset("rst2");
    apply(1'b0, 4'h0, 1'b1, 1'b0, "down1");
    check("down1 lit", {g, wrap}, {4'h8, 1'b1});
    apply(1'b0, 4'h0, 1'b1, 1'b0, "down2");
    check("down2 lit", {g, wrap}, {4'h9, 1'b0});

    apply(1'b1, 4'h5, 1'b0, 1'b0, "load5");
    check("load5 lit", {g, step, wrap}, {4'h7, 1'b0, 1'b0});
    apply(1'b0, 4'h0, 1'b1, 1'b1, "load5 up");
    check("load5 up lit", g, 4'h5);

    apply(1'b1, 4'hF, 1'b1, 1'b1, "loadwins");
    check("loadwins lit", {g, step}, {4'h8, 1'b0});
    apply(1'b0, 4'h0, 1'b1, 1'b1, "loadwins up");
    check("loadwins up lit", {g, wrap}, {4'h0, 1'b1});

    mid_reset("rst3");
    for (int i = 0; i < 4; i++) apply(1'b0, 4'h0, 1'b1, 1'b1, "pre_rst");
    check("pre_rst lit", g, 4'h6);
    mid_reset("async");
    apply(1'b0, 4'h0, 1'b1, 1'b1, "post_rst");
    check("post_rst lit", g, 4'h1);

    apply(1'b1, 4'h9, 1'b0, 1'b0, "load9");
    check("load9 lit", g, 4'hD);
    apply(1'b1, 4'h9, 1'b1, 1'b0, "reload");
    check("reload lit", {g, step}, {4'hD, 1'b0});
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 4'h0, 1'b0, 1'b1, "hold");
      check("hold lit", {g, step, wrap}, {4'hD, 1'b0, 1'b0});
    end
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 4'h0, 1'b1, 1'b1, "alt up");
      check("alt up lit", g, 4'hF);
      apply(1'b0, 4'h0, 1'b1, 1'b0, "alt dn");
      check("alt dn lit", g, 4'hD);
    end

    for (int i = 0; i < 40; i++) begin
      apply(($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
